// File: rtl/ls161.sv
// SN74LS161 model: synchronous 4-bit binary counter with asynchronous clear,
// synchronous parallel load and a combinational ripple-carry output.
module ls161 (
  input  logic _CLK,
  input  logic _CLR,
  input  logic _LOAD,
  input  logic _ENP,
  input  logic _ENT,
  input  logic _A,
  input  logic _B,
  input  logic _C,
  input  logic _D,
  output logic _QA,
  output logic _QB,
  output logic _QC,
  output logic _QD,
  output logic _RCO
);

  logic [3:0] count;

  // Clear overrides everything; then load beats count; otherwise hold.
  always_ff @(posedge _CLK or negedge _CLR) begin
    if (!_CLR) begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      count <= 4'b0000;
    end else if (!_LOAD) begin
      count <= {_D, _C, _B, _A};
    end else if (_ENP && _ENT) begin
      count <= count + 4'd1;
    end
  end

  assign {_QD, _QC, _QB, _QA} = count;

  // Carry depends only on _ENT and the terminal count, so cascaded stages
  // see it settle within the cycle and all stages update on the same edge.
  assign _RCO = _ENT & (&count);

endmodule

// File: doc/ls161.md
Name: ls161

Overview:
- Model of the SN74LS161: a synchronous 4-bit binary counter with direct (asynchronous) clear and synchronous parallel load.
- It sits directly upstream of the dual 2-to-4 decoder in the board logic.
- _QA/_QB drive the decoder's _A/_B select inputs, stepping the decoder through its four output strobes.
- _RCO cascades to further counter stages or gates the decoder enable.

Parameters:
- None. The fixed 4-bit width matches the physical part.

Ports:
- _CLK  input  1  clock; all state changes other than clear occur on the rising edge
- _CLR  input  1  direct clear, active-low, asynchronous (the block reset)
- _LOAD  input  1  synchronous parallel load, active-low
- _ENP  input  1  count enable P, active-high
- _ENT  input  1  count enable T, active-high; also gates _RCO
- _A  input  1  parallel data bit 0 (LSB)
- _B  input  1  parallel data bit 1
- _C  input  1  parallel data bit 2
- _D  input  1  parallel data bit 3 (MSB)
- _QA  output  1  count bit 0 (LSB)
- _QB  output  1  count bit 1
- _QC  output  1  count bit 2
- _QD  output  1  count bit 3 (MSB)
- _RCO  output  1  ripple carry out, active-high

Behaviour:
- Single clock _CLK. Reset _CLR is asynchronous and active-low.
- State: 4-bit count Q = {_QD,_QC,_QB,_QA}.
- Reset:
  - _CLR low forces Q=0000 immediately, with no clock needed. _RCO is therefore 0.
  - Clear overrides load, enables and clock for as long as it is held.
- Release of _CLR is synchronous-safe. The first rising _CLK edge after release is evaluated normally (load, count or hold). There is no extra dead cycle.
- Rising _CLK edge with _CLR high, evaluated in priority order:
  1. _LOAD low: Q <= {_D,_C,_B,_A}. Applies regardless of _ENP/_ENT.
  2. _LOAD high, _ENP high and _ENT high: Q <= Q+1, modulo 16 (1111 wraps to 0000).
  3. Otherwise: Q holds.
- Latency:
  - Load and count both take effect at the edge on which they are sampled; Q is visible after that edge.
  - Inputs must be stable around the edge. The bench drives them away from the edge.
- _RCO is combinational: _RCO = _ENT AND _QA AND _QB AND _QC AND _QD.
  - It is independent of _ENP, _LOAD and _CLK.
  - It is high for the whole cycle that Q=1111 with _ENT high, and falls as soon as Q leaves 1111 or _ENT drops.
- Simultaneous events:
  - _LOAD low together with enables high: the load wins.
  - Loading 1111 with _ENT high raises _RCO once Q updates.
  - _CLR low at a clock edge: the clear wins. Q=0000 and no load or count occurs.
- Reset mid-operation: asserting _CLR between edges clears Q at once. Q stays 0000 until release.
- Cascading: stage n+1 has its _ENT driven by stage n's _RCO and shares _CLK. The chain must count as one 8-bit binary counter with no ripple glitch on Q.
- X handling: an unknown on _CLR or _LOAD at an edge may produce X on Q. Under defined inputs, no X appears after the first clear.

Test Plan:
- Async clear: load 1010, then pulse _CLR low for 3ns between edges -> Q=0000 immediately with no clock; _RCO=0.
- Count and wrap: _CLR released, _LOAD=1, _ENP=_ENT=1, apply 17 edges -> Q steps 0001..1111,0000,0001.
  - _RCO=1 only during the 1111 cycle.
  - _QA/_QB driving a decoder yield its Y0..Y3 strobes in order.
- Load priority: Q=0101, _LOAD=0 with data 1100, _ENP=_ENT=1 at the edge -> Q=1100 (not 0110).
  - Next edge with _LOAD=1 -> Q=1101.
- Enable gating:
  - Q=0111, _ENP=0, _ENT=1 for 4 edges -> Q holds 0111.
  - Then _ENP=1, _ENT=0 -> Q still holds.
  - Load 1111 with _ENT=0 -> _RCO=0; raise _ENT -> _RCO=1 with no clock edge.
- Clear vs clock: hold _CLR low across 2 rising edges with _LOAD=0, data 1111 -> Q=0000 throughout.
  - Release _CLR mid-cycle -> next edge loads 1111.
- Cascade: two instances chained via _RCO->_ENT, start at 0x00 with enables high -> after 255 edges, combined value 0xFF with upper _RCO=1; next edge -> 0x00.
